// File: rtl/dr_receiver.sv
// Dual-rail, four-phase receiver: synchronizes both rails, assembles MSB-first
// words of WIDTH bits, and acknowledges every codeword/spacer transition.
module dr_receiver #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit0,
  input  logic             bit1,
  output logic             ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    WAIT_DATA,
    WAIT_SPACER,
    ERROR
  } state_t;

  logic [SYNC_STAGES-1:0] sync0, sync1;
  logic                   s0, s1;
  logic [1:0]             code;
  state_t                 state;
  logic [CW-1:0]          count;
  // The oldest bit is shifted out before it is ever read, so only WIDTH-1
  // bits of history are needed to form the assembled word.
  logic [WIDTH-2:0]       shreg;
  logic [WIDTH-1:0]       next_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= {sync0[SYNC_STAGES-2:0], bit0};
      sync1 <= {sync1[SYNC_STAGES-2:0], bit1};
    end
  end

  assign s0        = sync0[SYNC_STAGES-1];
  assign s1        = sync1[SYNC_STAGES-1];
  assign code      = {s1, s0};
  assign next_word = {shreg, s1};

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain updates within a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_DATA;
      ack        <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      err        <= 1'b0;
      shreg      <= '0;
      count      <= '0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        WAIT_DATA: begin
          if (code == 2'b11) begin
            state <= ERROR;
            err   <= 1'b1;
            ack   <= 1'b0;
          end else if (code != 2'b00) begin
            shreg <= next_word[WIDTH-2:0];
            ack   <= 1'b1;
            state <= WAIT_SPACER;
            if (count == CW'(WIDTH - 1)) begin
              data_out   <= next_word;
              data_valid <= 1'b1;
              count      <= '0;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        WAIT_SPACER: begin
          // A codeword still held here was already captured; only a spacer
          // or an illegal code moves the FSM on.
          if (code == 2'b11) begin
            state <= ERROR;
            err   <= 1'b1;
            ack   <= 1'b0;
          end else if (code == 2'b00) begin
            ack   <= 1'b0;
            state <= WAIT_DATA;
          end
        end
        ERROR: begin
          err <= 1'b1;
          ack <= 1'b0;
        end
        default: state <= WAIT_DATA;
      endcase
    end
  end

endmodule

// File: tb/tb_dr_receiver.sv
// Bench for dr_receiver: table-driven words, protocol corner sequences, and
// random four-phase traffic scored against a queue of sent words.
module tb_dr_receiver;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
  localparam int LAT   = SYNC + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             bit0 = 1'b0;
  logic             bit1 = 1'b0;
  logic             ack;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             err;

  dr_receiver #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .reset      (reset),
    .bit0       (bit0),
    .bit1       (bit1),
    .ack        (ack),
    .data_out   (data_out),
    .data_valid (data_valid),
    .err        (err)
  );

  always #5 clk = ~clk;

  int               checks = 0;
  int               errors = 0;
  int               strobes = 0;
  int               ack_rises = 0;
  logic             prev_ack = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  typedef struct {
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] exp_data;
    int               exp_strobes;
    int               exp_acks;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must coincide with an ack rise and deliver the
  // oldest word the sender has completed.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      strobes++;
      check("dv_with_ack_rise", 32'({prev_ack, ack}), 32'd1);
      if (exp_q.size() == 0)
        check("unexpected_strobe", 32'(data_valid), 32'd0);
      else
        check("dv_data", 32'(data_out), 32'(exp_q.pop_front()));
    end
    if (ack === 1'b1 && prev_ack === 1'b0) ack_rises++;
    prev_ack = ack;
  end

  // Called at a negedge; returns at a negedge with rails back at spacer.
  task automatic send_bit(input logic b, input int hold, input logic expect_ack);
    int n;
    bit0 = ~b;
    bit1 = b;
    if (expect_ack) begin
      n = 0;
      do begin @(negedge clk); n++; end while (ack !== 1'b1 && n < 50);
      check("ack_rise_latency", 32'(n), 32'(LAT));
      repeat (hold) @(negedge clk);
      check("ack_held", 32'(ack), 32'd1);
      bit0 = 1'b0;
      bit1 = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (ack !== 1'b0 && n < 50);
      check("ack_fall_latency", 32'(n), 32'(LAT));
    end else begin
      repeat (LAT + 3) @(negedge clk);
      check("ack_in_error", 32'(ack), 32'd0);
      bit0 = 1'b0;
      bit1 = 1'b0;
      repeat (LAT + 3) @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input int top, input int hold_max,
                           input logic expect_ack);
    for (int i = top; i >= 0; i--) begin
      send_bit(w[i], (hold_max > 0) ? int'($urandom_range(hold_max, 0)) : 0, expect_ack);
      if (hold_max > 0) repeat ($urandom_range(hold_max, 0)) @(negedge clk);
    end
  endtask

  task automatic pulse_reset_and_check();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int s0, r0, n;
    logic [WIDTH-1:0] w;

    vecs[0] = '{8'hA5, 8'hA5, 1, 8};
    vecs[1] = '{8'hFF, 8'hFF, 1, 8};
    vecs[2] = '{8'h00, 8'h00, 1, 8};
    vecs[3] = '{8'h3C, 8'h3C, 1, 8};
    vecs[4] = '{8'h01, 8'h01, 1, 8};
    vecs[5] = '{8'h80, 8'h80, 1, 8};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_data_out", 32'(data_out), 32'd0);
    check("reset_data_valid", 32'(data_valid), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Table: A5 alone, then FF and 00 back-to-back, then more patterns
    for (int i = 0; i < 6; i++) begin
      s0 = strobes;
      r0 = ack_rises;
      exp_q.push_back(vecs[i].word);
      send_word(vecs[i].word, WIDTH - 1, 0, 1'b1);
      check("vec_strobes", 32'(strobes - s0), 32'(vecs[i].exp_strobes));
      check("vec_ack_pulses", 32'(ack_rises - r0), 32'(vecs[i].exp_acks));
      check("vec_data_out", 32'(data_out), 32'(vecs[i].exp_data));
    end
    repeat (5) @(negedge clk);
    check("data_out_holds", 32'(data_out), 32'h80);
    check("dv_idle_low", 32'(data_valid), 32'd0);

    // Codeword held for 20 cycles is captured once
    r0 = ack_rises;
    s0 = strobes;
    send_bit(1'b1, 20, 1'b1);
    check("held_single_ack", 32'(ack_rises - r0), 32'd1);
    exp_q.push_back(8'hC3);
    send_word(8'hC3, WIDTH - 2, 0, 1'b1);
    check("held_word", 32'(data_out), 32'hC3);
    check("held_strobes", 32'(strobes - s0), 32'd1);

    // Reset mid-word discards the partial bits
    send_word(8'h05, 2, 0, 1'b1);
    pulse_reset_and_check();
    s0 = strobes;
    exp_q.push_back(8'h3C);
    send_word(8'h3C, WIDTH - 1, 0, 1'b1);
    check("after_reset_word", 32'(data_out), 32'h3C);
    check("after_reset_strobes", 32'(strobes - s0), 32'd1);

    // Illegal code: sticky error, no data until reset
    bit0 = 1'b1;
    bit1 = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (err !== 1'b1 && n < 50);
    check("err_latency", 32'(n), 32'(LAT));
    check("err_ack_low", 32'(ack), 32'd0);
    bit0 = 1'b0;
    bit1 = 1'b0;
    s0 = strobes;
    send_word(8'h3C, WIDTH - 1, 0, 1'b0);
    check("err_no_strobes", 32'(strobes - s0), 32'd0);
    check("err_sticky", 32'(err), 32'd1);
    check("err_data_holds", 32'(data_out), 32'h3C);
    pulse_reset_and_check();
    exp_q.push_back(8'h5A);
    send_word(8'h5A, WIDTH - 1, 0, 1'b1);
    check("post_err_word", 32'(data_out), 32'h5A);

    // Codeword present as reset falls: captured once, first bit of a word
    @(negedge clk);
    reset = 1'b1;
    bit1 = 1'b1;
    bit0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (ack !== 1'b1 && n < 50);
    check("reset_fall_capture_latency", 32'(n), 32'(LAT));
    bit1 = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (ack !== 1'b0 && n < 50);
    check("reset_fall_ack_fall", 32'(n), 32'(LAT));
    exp_q.push_back(8'h96);
    send_word(8'h96, WIDTH - 2, 0, 1'b1);
    check("reset_fall_word", 32'(data_out), 32'h96);

    // Random traffic with random holds and gaps
    s0 = strobes;
    for (int k = 0; k < 20; k++) begin
      w = WIDTH'($urandom);
      exp_q.push_back(w);
      send_word(w, WIDTH - 1, 3, 1'b1);
    end
    repeat (4) @(negedge clk);
    check("random_strobes", 32'(strobes - s0), 32'd20);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
